// File: rtl/vga_pkg.sv
// Shared video-subsystem definitions: memory window bases, write targets, arbiter FSM states.
package vga_pkg;

  // Default host-address windows for the video memories.
  localparam logic [13:0] FontBaseDef  = 14'h0000;
  localparam logic [13:0] PalBaseDef   = 14'h1000;
  localparam logic [13:0] ChrowBaseDef = 14'h1100;

  // Window sizes in words.
  localparam logic [13:0] FontWinSize  = 14'd4096;
  localparam logic [13:0] PalWinSize   = 14'd256;
  localparam logic [13:0] ChrowWinSize = 14'd256;

  typedef enum logic [1:0] {TGT_FONT, TGT_PAL, TGT_CHROW, TGT_NONE} tgt_e;

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  // Picks the target from base-relative offsets; offsets below a base wrap to large values
  // and so fall outside the window. Font wins if windows were ever configured to overlap.
  function automatic tgt_e decode_tgt(input logic [13:0] font_off, input logic [13:0] pal_off,
                                      input logic [13:0] chrow_off);
    if (font_off < FontWinSize) begin
      return TGT_FONT;
    end else if (pal_off < PalWinSize) begin
      return TGT_PAL;
    end else if (chrow_off < ChrowWinSize) begin
      return TGT_CHROW;
    end
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO with first-word fall-through read and a registered full flag.
module wr_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned   PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;
  localparam logic [PtrW:0]   CntMax = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Full is the registered flag, so a push in the same cycle as a pop from a full FIFO is refused.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntOne;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntOne;
    end
  end

  // Pointers, count and full flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full    <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      count_q <= count_d;
      full    <= (count_d == CntMax);
    end
  end

  // Storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/vram_wr_arbiter.sv
// Host write scheduler: queues host writes and issues them to the font, palette and
// character-row memories one word per cycle, holding row-buffer writes while rendering.
module vram_wr_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [13:0] FONT_BASE  = FontBaseDef,
  parameter logic [13:0] PAL_BASE   = PalBaseDef,
  parameter logic [13:0] CHROW_BASE = ChrowBaseDef
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        host_wr,
  input  logic [13:0] host_addr,
  input  logic [15:0] host_data,
  output logic        host_full,
  input  logic        render_busy,
  output logic        fontmem_wr,
  output logic [11:0] fontmem_wr_addr,
  output logic [7:0]  fontmem_wr_data,
  output logic        palette_wr,
  output logic [7:0]  palette_wr_addr,
  output logic [15:0] palette_wr_data,
  output logic        chrowbuf_wr,
  output logic [7:0]  chrowbuf_wr_addr,
  output logic [15:0] chrowbuf_wr_data,
  output logic        ovf,
  output logic [7:0]  bad_count
);

  logic [29:0] head;
  logic [13:0] head_addr;
  logic [15:0] head_data;
  logic        fifo_empty;
  logic        pop;
  logic [13:0] font_off, pal_off, chrow_off;
  tgt_e        head_tgt, tgt_q;
  state_e      state_q, state_d;

  wr_fifo #(
    .Width(30),
    .Depth(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk  (clk),
    .nrst (nrst),
    .push (host_wr),
    .wdata({host_addr, host_data}),
    .pop  (pop),
    .rdata(head),
    .empty(fifo_empty),
    .full (host_full)
  );

  assign head_addr = head[29:16];
  assign head_data = head[15:0];
  assign font_off  = head_addr - FONT_BASE;
  assign pal_off   = head_addr - PAL_BASE;
  assign chrow_off = head_addr - CHROW_BASE;
  assign head_tgt  = decode_tgt(font_off, pal_off, chrow_off);

  // Next state: issue the head unless it is a row-buffer write while the renderer is busy.
  always_comb begin
    state_d = StIdle;
    pop     = 1'b0;
    if (!fifo_empty) begin
      if (head_tgt == TGT_CHROW && render_busy) begin
        state_d = StHold;
      end else begin
        state_d = StIssue;
        pop     = 1'b1;
      end
    end
  end

  // State and the target of the word being issued this cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      tgt_q   <= TGT_NONE;
    end else begin
      state_q <= state_d;
      tgt_q   <= head_tgt;
    end
  end

  // At most one strobe low, for one cycle per issued word; unmapped words strobe nothing.
  assign fontmem_wr  = !(state_q == StIssue && tgt_q == TGT_FONT);
  assign palette_wr  = !(state_q == StIssue && tgt_q == TGT_PAL);
  assign chrowbuf_wr = !(state_q == StIssue && tgt_q == TGT_CHROW);

  // Per-memory address/data, updated only when that memory is written, otherwise held.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      fontmem_wr_addr  <= '0;
      fontmem_wr_data  <= '0;
      palette_wr_addr  <= '0;
      palette_wr_data  <= '0;
      chrowbuf_wr_addr <= '0;
      chrowbuf_wr_data <= '0;
    end else if (state_d == StIssue) begin
      case (head_tgt)
        TGT_FONT: begin
          fontmem_wr_addr <= font_off[11:0];
          fontmem_wr_data <= head_data[7:0];
        end
        TGT_PAL: begin
          palette_wr_addr <= pal_off[7:0];
          palette_wr_data <= head_data;
        end
        TGT_CHROW: begin
          chrowbuf_wr_addr <= chrow_off[7:0];
          chrowbuf_wr_data <= head_data;
        end
        default: ;
      endcase
    end
  end

  // Error status: sticky overflow and saturating count of dropped unmapped writes.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ovf       <= 1'b0;
      bad_count <= '0;
    end else begin
      if (host_wr && host_full) ovf <= 1'b1;
      if (state_d == StIssue && head_tgt == TGT_NONE && bad_count != 8'hff) begin
        bad_count <= bad_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter with hand-computed expectations.
module tb_vram_wr_arbiter;

  logic        clk;
  logic        nrst;
  logic        host_wr;
  logic [13:0] host_addr;
  logic [15:0] host_data;
  logic        host_full;
  logic        render_busy;
  logic        fontmem_wr;
  logic [11:0] fontmem_wr_addr;
  logic [7:0]  fontmem_wr_data;
  logic        palette_wr;
  logic [7:0]  palette_wr_addr;
  logic [15:0] palette_wr_data;
  logic        chrowbuf_wr;
  logic [7:0]  chrowbuf_wr_addr;
  logic [15:0] chrowbuf_wr_data;
  logic        ovf;
  logic [7:0]  bad_count;

  int n_checks = 0;
  int n_errors = 0;

  vram_wr_arbiter #(
    .FIFO_DEPTH(4)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .host_wr         (host_wr),
    .host_addr       (host_addr),
    .host_data       (host_data),
    .host_full       (host_full),
    .render_busy     (render_busy),
    .fontmem_wr      (fontmem_wr),
    .fontmem_wr_addr (fontmem_wr_addr),
    .fontmem_wr_data (fontmem_wr_data),
    .palette_wr      (palette_wr),
    .palette_wr_addr (palette_wr_addr),
    .palette_wr_data (palette_wr_data),
    .chrowbuf_wr     (chrowbuf_wr),
    .chrowbuf_wr_addr(chrowbuf_wr_addr),
    .chrowbuf_wr_data(chrowbuf_wr_data),
    .ovf             (ovf),
    .bad_count       (bad_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs and samples live there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [13:0] addr, input logic [15:0] data);
    host_wr   = wr;
    host_addr = addr;
    host_data = data;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_font"}, {31'd0, fontmem_wr}, 32'd1);
    check({tag, "_pal"}, {31'd0, palette_wr}, 32'd1);
    check({tag, "_chrow"}, {31'd0, chrowbuf_wr}, 32'd1);
  endtask

  initial begin
    int nlow;
    nrst = 1'b0;
    render_busy = 1'b0;
    drive(1'b0, 14'h0, 16'h0);
    step();
    step();
    // Reset values
    check_quiet("rst");
    check("rst_faddr", 32'(fontmem_wr_addr), 32'h0);
    check("rst_fdata", 32'(fontmem_wr_data), 32'h0);
    check("rst_paddr", 32'(palette_wr_addr), 32'h0);
    check("rst_pdata", 32'(palette_wr_data), 32'h0);
    check("rst_caddr", 32'(chrowbuf_wr_addr), 32'h0);
    check("rst_cdata", 32'(chrowbuf_wr_data), 32'h0);
    check("rst_full", 32'(host_full), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_bad", 32'(bad_count), 32'h0);
    nrst = 1'b1;
    step();

    // Single palette write: strobe in N+2
    drive(1'b1, 14'h1003, 16'h0ff0);
    step();
    drive(1'b0, 14'h0, 16'h0);
    check_quiet("pal_n1");
    step();
    check("pal_n2_wr", 32'(palette_wr), 32'h0);
    check("pal_n2_addr", 32'(palette_wr_addr), 32'h03);
    check("pal_n2_data", 32'(palette_wr_data), 32'h0ff0);
    check("pal_n2_font", 32'(fontmem_wr), 32'h1);
    check("pal_n2_chrow", 32'(chrowbuf_wr), 32'h1);
    step();
    check_quiet("pal_n3");
    check("pal_hold_addr", 32'(palette_wr_addr), 32'h03);

    // Font burst: four consecutive strobes, never full
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 14'(i), 16'(8'h11 * (i + 1)));
      else       drive(1'b0, 14'h0, 16'h0);
      check("burst_full", 32'(host_full), 32'h0);
      if (i >= 2) begin
        check("burst_wr", 32'(fontmem_wr), 32'h0);
        check("burst_addr", 32'(fontmem_wr_addr), 32'(i - 2));
        check("burst_data", 32'(fontmem_wr_data), 32'(8'h11 * (i - 1)));
        check("burst_pal", 32'(palette_wr), 32'h1);
      end
      step();
    end
    check_quiet("burst_end");
    check("burst_hold_addr", 32'(fontmem_wr_addr), 32'h3);

    // chrowbuf hold: later palette entry waits behind the held row write
    render_busy = 1'b1;
    drive(1'b1, 14'h1105, 16'haaaa);
    step();
    drive(1'b1, 14'h1000, 16'h5555);
    step();
    drive(1'b0, 14'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      check_quiet("hold_busy");
      step();
    end
    render_busy = 1'b0;  // cycle M
    check_quiet("hold_m");
    step();
    check("hold_m1_chrow", 32'(chrowbuf_wr), 32'h0);
    check("hold_m1_addr", 32'(chrowbuf_wr_addr), 32'h05);
    check("hold_m1_data", 32'(chrowbuf_wr_data), 32'haaaa);
    check("hold_m1_pal", 32'(palette_wr), 32'h1);
    step();
    check("hold_m2_pal", 32'(palette_wr), 32'h0);
    check("hold_m2_addr", 32'(palette_wr_addr), 32'h00);
    check("hold_m2_data", 32'(palette_wr_data), 32'h5555);
    check("hold_m2_chrow", 32'(chrowbuf_wr), 32'h1);
    step();
    check_quiet("hold_m3");

    // Overflow: five pushes into a held depth-4 FIFO
    check("pre_ovf", 32'(ovf), 32'h0);
    render_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 14'h1110 + 14'(i), 16'hc000 + 16'(i));
      check("ovf_full", 32'(host_full), (i == 4) ? 32'h1 : 32'h0);
      step();
    end
    drive(1'b0, 14'h0, 16'h0);
    render_busy = 1'b0;
    check("ovf_flag", 32'(ovf), 32'h1);
    check("ovf_full_held", 32'(host_full), 32'h1);
    step();
    nlow = 0;
    for (int j = 0; j < 7; j++) begin
      if (chrowbuf_wr == 1'b0) begin
        check("ovf_addr", 32'(chrowbuf_wr_addr), 32'h10 + 32'(nlow));
        check("ovf_data", 32'(chrowbuf_wr_data), 32'hc000 + 32'(nlow));
        nlow++;
      end
      step();
    end
    check("ovf_count", 32'(nlow), 32'd4);

    // Unmapped addresses
    drive(1'b1, 14'h2000, 16'h1234);
    step();
    drive(1'b0, 14'h0, 16'h0);
    step();
    check_quiet("unmap_n2");
    step();
    check("unmap_bad1", 32'(bad_count), 32'd1);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 14'h2000 + 14'(k), 16'(k));
      if (k > 2) check_quiet("unmap_run");
      step();
    end
    drive(1'b0, 14'h0, 16'h0);
    for (int k = 0; k < 4; k++) step();
    check("unmap_sat", 32'(bad_count), 32'd255);
    check("ovf_sticky", 32'(ovf), 32'h1);

    // Reset with three held entries queued
    render_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 14'h1101 + 14'(i), 16'h7000 + 16'(i));
      step();
    end
    drive(1'b0, 14'h0, 16'h0);
    check("mid_full_pre", 32'(host_full), 32'h0);
    nrst = 1'b0;
    render_busy = 1'b0;
    step();
    check_quiet("mid_rst");
    check("mid_full", 32'(host_full), 32'h0);
    check("mid_ovf", 32'(ovf), 32'h0);
    check("mid_bad", 32'(bad_count), 32'h0);
    nrst = 1'b1;
    nlow = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (!fontmem_wr || !palette_wr || !chrowbuf_wr) nlow++;
    end
    check("mid_no_issue", 32'(nlow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
